// File: rtl/pixel_stream_sink.sv
// pixel_stream_sink
//   Receiving end of the Pixel/Frame/Line video stream. Pixels are valid while
//   Frame and Line are both high. A one-word hold stage lets each pixel be tagged
//   with end-of-line / end-of-frame once its successor cycle is known. Tagged
//   words {EOF, EOL, SOF, SOL, Pixel} are buffered in a FIFO and leave over a
//   valid/ready port. Frame and line statistics are kept alongside.
module pixel_stream_sink #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        Clk,
  input  logic        nReset,
  input  logic [7:0]  Pixel,
  input  logic        Frame,
  input  logic        Line,
  output logic [11:0] OutData,
  output logic        OutValid,
  input  logic        OutReady,
  output logic        Overflow,
  output logic [15:0] FrameCount,
  output logic [15:0] LineCount
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  typedef logic [DEPTH_LOG2:0]   ptr_t;
  typedef logic [DEPTH_LOG2-1:0] addr_t;

  typedef struct packed {
    logic       eof;
    logic       eol;
    logic       sof;
    logic       sol;
    logic [7:0] pixel;
  } word_t;

  // What the hold stage does this cycle; exactly one applies.
  typedef enum logic [2:0] {
    ACT_IDLE,        // nothing held, nothing arriving
    ACT_PUSH_LOAD,   // held word continues the line: push it, load new pixel
    ACT_CLOSE_LINE,  // held word is the last of its line: push it tagged EOL
    ACT_FRAME_END,   // frame ended with nothing held: push a bare EOF word
    ACT_LOAD         // first pixel of a line: load it, nothing to push yet
  } hold_act_e;

  // Input edge detection and start-of flags
  logic       frame_prev_q, line_prev_q;
  logic       sof_pend_q, sof_pend_d;
  logic       sol_pend_q, sol_pend_d;
  logic       pix_valid, frame_rise, frame_fall, line_rise;
  logic       cur_sof, cur_sol;

  // Hold stage
  logic       hold_valid_q, hold_valid_d;
  logic       hold_sof_q, hold_sof_d;
  logic       hold_sol_q, hold_sol_d;
  logic [7:0] hold_pix_q, hold_pix_d;
  hold_act_e  act;
  logic       push_en, load_en;
  word_t      push_word;

  // Statistics
  logic [15:0] frame_count_q, frame_count_d;
  logic [15:0] line_count_q, line_count_d;
  logic        overflow_q, overflow_d;

  // FIFO
  word_t      mem [DEPTH];
  ptr_t       wr_ptr_q, wr_ptr_d;
  ptr_t       rd_ptr_q, rd_ptr_d;
  addr_t      wr_addr, rd_addr;
  logic       fifo_empty, fifo_full, pop_en, wr_en;

  assign pix_valid  = Frame & Line;
  assign frame_rise = Frame & ~frame_prev_q;
  assign frame_fall = frame_prev_q & ~Frame;
  // A Line rise only counts while a frame is active; stray lines are ignored.
  assign line_rise  = Line & ~line_prev_q & Frame;
  // A rise in the same cycle as the pixel must tag it directly, since the
  // pending flag only becomes visible a cycle later.
  assign cur_sof    = sof_pend_q | frame_rise;
  assign cur_sol    = sol_pend_q | line_rise;

  // Classify the cycle into one hold-stage action.
  always_comb begin
    // NOTE: every signal driven from an always_comb gets a default on entry;
    // a path that leaves one unassigned would infer a latch.
    act = ACT_IDLE;
    if (hold_valid_q && pix_valid) begin
      act = ACT_PUSH_LOAD;
    end else if (hold_valid_q) begin
      act = ACT_CLOSE_LINE;
    end else if (frame_fall) begin
      act = ACT_FRAME_END;
    end else if (pix_valid) begin
      act = ACT_LOAD;
    end
  end

  // Build the word to push and decide whether the current pixel is captured.
  always_comb begin
    push_en   = 1'b0;
    load_en   = 1'b0;
    push_word = '0;
    unique case (act)
      ACT_PUSH_LOAD: begin
        push_en         = 1'b1;
        load_en         = 1'b1;
        push_word.sof   = hold_sof_q;
        push_word.sol   = hold_sol_q;
        push_word.pixel = hold_pix_q;
      end
      ACT_CLOSE_LINE: begin
        push_en         = 1'b1;
        push_word.eof   = ~Frame;  // Frame falling with Line ends the frame here
        push_word.eol   = 1'b1;
        push_word.sof   = hold_sof_q;
        push_word.sol   = hold_sol_q;
        push_word.pixel = hold_pix_q;
      end
      ACT_FRAME_END: begin
        push_en       = 1'b1;
        push_word.eof = 1'b1;
      end
      ACT_LOAD: begin
        load_en = 1'b1;
      end
      default: begin
        push_en = 1'b0;
      end
    endcase
  end

  // Next state of the hold register, start flags and statistics counters.
  always_comb begin
    hold_valid_d  = hold_valid_q;
    hold_sof_d    = hold_sof_q;
    hold_sol_d    = hold_sol_q;
    hold_pix_d    = hold_pix_q;
    sof_pend_d    = sof_pend_q | frame_rise;
    sol_pend_d    = sol_pend_q | line_rise;
    line_count_d  = line_count_q;
    frame_count_d = frame_count_q;

    if (load_en) begin
      hold_valid_d = 1'b1;
      hold_sof_d   = cur_sof;
      hold_sol_d   = cur_sol;
      hold_pix_d   = Pixel;
      // Both flags have just been attached to this pixel.
      sof_pend_d   = 1'b0;
      sol_pend_d   = 1'b0;
    end else if (act == ACT_CLOSE_LINE) begin
      hold_valid_d = 1'b0;
    end

    if (load_en && cur_sof) begin
      line_count_d = '0;
    end else if (act == ACT_CLOSE_LINE) begin
      line_count_d = line_count_q + 16'd1;
    end

    // Counted on the push itself, so a dropped EOF word still counts.
    if (push_en && push_word.eof) begin
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  // FIFO status and handshake; a pop frees a slot for a write in the same cycle.
  assign wr_addr    = wr_ptr_q[DEPTH_LOG2-1:0];
  assign rd_addr    = rd_ptr_q[DEPTH_LOG2-1:0];
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                      (wr_addr == rd_addr);
  assign pop_en     = ~fifo_empty & OutReady;
  assign wr_en      = push_en & (~fifo_full | pop_en);

  // FIFO pointer advance and sticky overflow.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + ptr_t'(1);
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end
    if (push_en && !wr_en) begin
      overflow_d = 1'b1;
    end
  end

  // State registers; reset discards any buffered data and clears the counters.
  always_ff @(posedge Clk or negedge nReset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the clock edge, independent of order.
    if (!nReset) begin
      frame_prev_q  <= 1'b0;
      line_prev_q   <= 1'b0;
      sof_pend_q    <= 1'b0;
      sol_pend_q    <= 1'b0;
      hold_valid_q  <= 1'b0;
      hold_sof_q    <= 1'b0;
      hold_sol_q    <= 1'b0;
      hold_pix_q    <= '0;
      frame_count_q <= '0;
      line_count_q  <= '0;
      overflow_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      frame_prev_q  <= Frame;
      line_prev_q   <= Line;
      sof_pend_q    <= sof_pend_d;
      sol_pend_q    <= sol_pend_d;
      hold_valid_q  <= hold_valid_d;
      hold_sof_q    <= hold_sof_d;
      hold_sol_q    <= hold_sol_d;
      hold_pix_q    <= hold_pix_d;
      frame_count_q <= frame_count_d;
      line_count_q  <= line_count_d;
      overflow_q    <= overflow_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // FIFO storage write.
  always_ff @(posedge Clk) begin
    // NOTE: the storage array has no reset; clearing the pointers empties the
    // FIFO, and gating the output keeps stale contents invisible.
    if (wr_en) begin
      mem[wr_addr] <= push_word;
    end
  end

  assign OutValid   = ~fifo_empty;
  assign OutData    = fifo_empty ? 12'h000 : mem[rd_addr];
  assign Overflow   = overflow_q;
  assign FrameCount = frame_count_q;
  assign LineCount  = line_count_q;

  // A stalled output word stays presented and unchanged until accepted.
  assert property (@(posedge Clk) disable iff (!nReset)
                   (OutValid && !OutReady) |=> (OutValid && $stable(OutData)));

endmodule

// File: tb/tb_pixel_stream_sink.sv
// tb_pixel_stream_sink
//   Drives frames described as lists of lines, predicts the tagged word stream
//   from the frame structure, and compares it against the output port from an
//   independent monitor process.
module tb_pixel_stream_sink;

  localparam int DEPTH_LOG2 = 4;

  logic        Clk = 1'b0;
  logic        nReset;
  logic [7:0]  Pixel;
  logic        Frame;
  logic        Line;
  logic [11:0] OutData;
  logic        OutValid;
  logic        OutReady;
  logic        Overflow;
  logic [15:0] FrameCount;
  logic [15:0] LineCount;

  int          checks   = 0;
  int          failures = 0;
  logic [11:0] exp_q [$];
  logic [11:0] mon_exp;
  int          rdy_mode;          // 0: random ready, 1: driven by the stimulus
  logic [15:0] mdl_frames;
  int          mdl_lines;

  // Current frame description
  int          f_lead, f_gap, f_tail, f_nlines;
  int          f_len [4];
  logic [7:0]  f_px  [4][64];

  pixel_stream_sink #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .Clk        (Clk),
    .nReset     (nReset),
    .Pixel      (Pixel),
    .Frame      (Frame),
    .Line       (Line),
    .OutData    (OutData),
    .OutValid   (OutValid),
    .OutReady   (OutReady),
    .Overflow   (Overflow),
    .FrameCount (FrameCount),
    .LineCount  (LineCount)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted word is compared with the oldest prediction.
  always @(negedge Clk) begin
    if (nReset && OutValid && OutReady) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word: got 0x%03h want none at %0t", OutData, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("out_word", 32'(OutData), 32'(mon_exp));
      end
    end
  end

  // Random consumer back-pressure.
  always @(posedge Clk) begin
    #1;
    if (rdy_mode == 0) OutReady = ($urandom_range(3, 0) != 0);
  end

  // One input cycle; returns just after the clock edge that sampled it.
  task automatic drive(input logic f, input logic l, input logic [7:0] p);
    Frame = f;
    Line  = l;
    Pixel = p;
    @(posedge Clk);
    #1;
  endtask

  task automatic new_frame(input int lead, input int gap, input int tail);
    f_lead   = lead;
    f_gap    = gap;
    f_tail   = tail;
    f_nlines = 0;
  endtask

  // mode 0: constant base, 1: incrementing from base, 2: random
  task automatic add_line(input int len, input logic [7:0] base, input int mode);
    f_len[f_nlines] = len;
    for (int i = 0; i < len; i++) begin
      case (mode)
        0:       f_px[f_nlines][i] = base;
        1:       f_px[f_nlines][i] = 8'(int'(base) + i);
        default: f_px[f_nlines][i] = 8'($urandom);
      endcase
    end
    f_nlines++;
  endtask

  // Expected words from the frame structure: SOL on the first pixel of a line,
  // SOF on the first of the frame, EOL on the last of a line, EOF on the last
  // pixel when Frame drops with Line, else a bare EOF word after a tail.
  task automatic model_frame(input int limit);
    int          n;
    logic [11:0] w;
    n = 0;
    for (int l = 0; l < f_nlines; l++) begin
      for (int i = 0; i < f_len[l]; i++) begin
        w = {4'b0000, f_px[l][i]};
        if (i == 0) w[8] = 1'b1;
        if (l == 0 && i == 0) w[9] = 1'b1;
        if (i == f_len[l] - 1) begin
          w[10] = 1'b1;
          if (l == f_nlines - 1 && f_tail == 0) w[11] = 1'b1;
        end
        if (n < limit) exp_q.push_back(w);
        n++;
      end
    end
    if (f_tail > 0) begin
      if (n < limit) exp_q.push_back(12'h800);
      n++;
    end
    mdl_frames = mdl_frames + 16'd1;
    mdl_lines  = f_nlines;
  endtask

  task automatic drive_frame();
    for (int i = 0; i < f_lead; i++) drive(1'b1, 1'b0, 8'($urandom));
    for (int l = 0; l < f_nlines; l++) begin
      for (int i = 0; i < f_len[l]; i++) drive(1'b1, 1'b1, f_px[l][i]);
      if (l != f_nlines - 1)
        for (int g = 0; g < f_gap; g++) drive(1'b1, 1'b0, 8'($urandom));
    end
    for (int t = 0; t < f_tail; t++) drive(1'b1, 1'b0, 8'($urandom));
    drive(1'b0, 1'b0, 8'($urandom));
    drive(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge Clk);
      #1;
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    repeat (3) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic check_counts(input string name);
    check({name, "_frame_count"}, 32'(FrameCount), 32'(mdl_frames));
    check({name, "_line_count"}, 32'(LineCount), 32'(mdl_lines));
  endtask

  task automatic apply_reset();
    nReset = 1'b0;
    Frame  = 1'b0;
    Line   = 1'b0;
    Pixel  = 8'h00;
    exp_q.delete();
    mdl_frames = 16'd0;
    mdl_lines  = 0;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_out_valid", 32'(OutValid), 32'd0);
    check("rst_out_data", 32'(OutData), 32'd0);
    check("rst_overflow", 32'(Overflow), 32'd0);
    check("rst_frame_count", 32'(FrameCount), 32'd0);
    check("rst_line_count", 32'(LineCount), 32'd0);
    nReset = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    nReset     = 1'b0;
    Frame      = 1'b0;
    Line       = 1'b0;
    Pixel      = 8'h00;
    OutReady   = 1'b0;
    rdy_mode   = 1;
    mdl_frames = 16'd0;
    mdl_lines  = 0;
    #2;
    apply_reset();

    // Two lines of three pixels, Frame falls together with the last Line.
    OutReady = 1'b1;
    new_frame(1, 1, 0);
    add_line(3, 8'h10, 1);
    add_line(3, 8'h13, 1);
    exp_q.push_back(12'h310); exp_q.push_back(12'h011); exp_q.push_back(12'h412);
    exp_q.push_back(12'h113); exp_q.push_back(12'h014); exp_q.push_back(12'hC15);
    drive_frame();
    wait_drain("t1_drain");
    check("t1_frame_count", 32'(FrameCount), 32'd1);
    check("t1_line_count", 32'(LineCount), 32'd2);

    // Same frame, Frame stays high two cycles past the last line.
    new_frame(1, 1, 2);
    add_line(3, 8'h10, 1);
    add_line(3, 8'h13, 1);
    exp_q.push_back(12'h310); exp_q.push_back(12'h011); exp_q.push_back(12'h412);
    exp_q.push_back(12'h113); exp_q.push_back(12'h014); exp_q.push_back(12'h415);
    exp_q.push_back(12'h800);
    drive_frame();
    wait_drain("t2_drain");
    check("t2_frame_count", 32'(FrameCount), 32'd2);
    check("t2_line_count", 32'(LineCount), 32'd2);

    // Frame and Line rise and fall together around four 0xAA pixels.
    new_frame(0, 1, 0);
    add_line(4, 8'hAA, 0);
    exp_q.push_back(12'h3AA); exp_q.push_back(12'h0AA);
    exp_q.push_back(12'h0AA); exp_q.push_back(12'hCAA);
    drive_frame();
    wait_drain("t6_drain");
    check("t6_frame_count", 32'(FrameCount), 32'd3);
    check("t6_line_count", 32'(LineCount), 32'd1);
    mdl_frames = 16'd3;

    // Random frames under random back-pressure; one frame never exceeds the FIFO.
    rdy_mode = 0;
    for (int k = 0; k < 24; k++) begin
      int nl;
      nl = int'($urandom_range(3, 1));
      new_frame(int'($urandom_range(2, 0)), int'($urandom_range(3, 1)),
                int'($urandom_range(2, 0)));
      for (int l = 0; l < nl; l++) add_line(int'($urandom_range(5, 1)), 8'h00, 2);
      model_frame(1000);
      drive_frame();
      check_counts("rnd");
      wait_drain("rnd_drain");
      if (k == 10) begin
        // Line activity outside a frame produces nothing.
        drive(1'b0, 1'b1, 8'h5A);
        drive(1'b0, 1'b1, 8'h5B);
        drive(1'b0, 1'b1, 8'h5C);
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        check("stray_line_valid", 32'(OutValid), 32'd0);
        check_counts("stray_line");
      end
    end

    // Reset mid-line with five words queued.
    rdy_mode = 1;
    OutReady = 1'b0;
    drive(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 8'(8'h40 + i));
    check("t5_pre_valid", 32'(OutValid), 32'd1);
    nReset = 1'b0;
    #1;
    check("t5_out_valid", 32'(OutValid), 32'd0);
    check("t5_frame_count", 32'(FrameCount), 32'd0);
    check("t5_line_count", 32'(LineCount), 32'd0);
    apply_reset();
    OutReady = 1'b1;
    new_frame(0, 1, 1);
    add_line(2, 8'h00, 2);
    add_line(3, 8'h00, 2);
    model_frame(1000);
    drive_frame();
    wait_drain("t5_post_drain");
    check_counts("t5_post");

    // Consumer stalled through a 40-pixel line: first 16 words kept in order.
    OutReady = 1'b0;
    new_frame(0, 1, 0);
    add_line(40, 8'h00, 2);
    model_frame(1 << DEPTH_LOG2);
    drive_frame();
    check("t3_overflow", 32'(Overflow), 32'd1);
    check("t3_valid", 32'(OutValid), 32'd1);
    check_counts("t3");
    OutReady = 1'b1;
    wait_drain("t3_drain");
    check("t3_overflow_sticky", 32'(Overflow), 32'd1);
    check("t3_empty", 32'(OutValid), 32'd0);
    apply_reset();

    // FIFO full, then one write in the same cycle as a read: nothing dropped.
    OutReady = 1'b0;
    new_frame(0, 1, 0);
    add_line(17, 8'h00, 2);
    model_frame(1000);
    for (int i = 0; i < 17; i++) drive(1'b1, 1'b1, f_px[0][i]);
    OutReady = 1'b1;
    drive(1'b0, 1'b0, 8'h00);
    OutReady = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    check("t4_overflow", 32'(Overflow), 32'd0);
    check_counts("t4");
    OutReady = 1'b1;
    wait_drain("t4_drain");
    check("t4_empty", 32'(OutValid), 32'd0);
    check("t4_overflow_end", 32'(Overflow), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Overall time bound.
  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
